// File: rtl/poly2mono_pkg.sv
// Shared types for the polyphonic-to-monophonic note priority block.
package poly2mono_pkg;

  typedef enum logic [1:0] {
    PRIO_LAST,
    PRIO_HIGH,
    PRIO_LOW
  } prio_mode_t;

  typedef logic [6:0] note_t;
  typedef logic [6:0] vel_t;

  typedef struct packed {
    note_t note;
    vel_t  vel;
  } entry_t;

endpackage

// File: rtl/note_stack.sv
// Held-note stack, oldest at index 0 and newest at count-1, with a serial search port.
// Full-stack policy: POLY2MONO_STEAL_EN evicts the oldest note, otherwise the new note is dropped.
module note_stack
  import poly2mono_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       search_clr_i,
  input  logic                       search_en_i,
  input  logic [$clog2(DEPTH)-1:0]   idx_i,
  input  note_t                      key_i,
  input  logic                       update_en_i,
  input  logic                       note_on_i,
  input  entry_t                     new_entry_i,
  output entry_t                     rd_entry_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t        stack_q [DEPTH];
  entry_t        stack_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          hit_q;
  logic [IW-1:0] hit_idx_q;
  logic          full, remove, append, in_use;
  logic [IW-1:0] rm_idx, app_idx;

  always_comb begin
    full   = (count_q == CW'(DEPTH));
    in_use = (CW'(idx_i) < count_q);
`ifdef POLY2MONO_STEAL_EN
    remove = hit_q | (note_on_i & full);
    append = note_on_i;
`else
    remove = hit_q;
    append = note_on_i & (hit_q | ~full);
`endif
    // With no hit, a removal can only be the eviction of the oldest entry.
    rm_idx  = hit_q ? hit_idx_q : '0;
    app_idx = IW'(count_q - CW'(remove));
    count_d = count_q + CW'(append) - CW'(remove);
    for (int i = 0; i < int'(DEPTH); i++) stack_d[i] = stack_q[i];
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (remove && i >= int'(rm_idx)) stack_d[i] = stack_q[i + 1];
    end
    if (append) stack_d[app_idx] = new_entry_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
      count_q   <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
    end else begin
      if (search_clr_i) begin
        hit_q     <= 1'b0;
        hit_idx_q <= '0;
      end else if (search_en_i && !hit_q && in_use && stack_q[idx_i].note == key_i) begin
        hit_q     <= 1'b1;
        hit_idx_q <= idx_i;
      end
      if (update_en_i) begin
        for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= stack_d[i];
        count_q <= count_d;
      end
    end
  end

  assign rd_entry_o = stack_q[idx_i];
  assign count_o    = count_q;

endmodule

// File: rtl/poly2mono_prio.sv
// Poly-to-mono note priority: event handshake FSM, priority selection and registered outputs.
// Full-stack behaviour is set by POLY2MONO_STEAL_EN inside note_stack.
module poly2mono_prio
  import poly2mono_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter prio_mode_t  MODE  = PRIO_LAST
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       valid_in,
  output logic                       ready,
  input  logic                       note_on_in,
  input  logic [6:0]                 note_num_in,
  input  logic [6:0]                 velocity_in,
  output logic                       note_on_out,
  output logic [6:0]                 note_num_out,
  output logic [6:0]                 velocity_out,
  output logic                       trig_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [IW:0] ScanLast = (IW + 1)'(DEPTH - 1);
  localparam logic [IW:0] ScanEnd  = (IW + 1)'(DEPTH);
  localparam logic [IW:0] CntOne   = (IW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StSearch, StUpdate, StSelect} state_t;

  state_t        state_q;
  logic [IW:0]   cnt_q;
  logic          ev_on_q;
  note_t         ev_note_q;
  vel_t          ev_vel_q;
  entry_t        best_q;
  logic          best_vld_q;
  logic          ready_q, on_q, trig_q;
  note_t         note_q;
  vel_t          vel_q;

  entry_t        rd_entry, new_entry;
  logic [CW-1:0] count;
  logic          search_clr, search_en, update_en, take;

  assign search_clr = (state_q == StIdle) && valid_in;
  assign search_en  = (state_q == StSearch);
  assign update_en  = (state_q == StUpdate);
  assign new_entry  = '{note: ev_note_q, vel: ev_vel_q};

  note_stack #(
    .DEPTH (DEPTH)
  ) u_note_stack (
    .clk          (clk),
    .reset_n      (reset_n),
    .search_clr_i (search_clr),
    .search_en_i  (search_en),
    .idx_i        (cnt_q[IW-1:0]),
    .key_i        (ev_note_q),
    .update_en_i  (update_en),
    .note_on_i    (ev_on_q),
    .new_entry_i  (new_entry),
    .rd_entry_o   (rd_entry),
    .count_o      (count)
  );

  // Scan runs oldest to newest, so for PRIO_LAST the final in-range entry wins.
  always_comb begin
    case (MODE)
      PRIO_HIGH: take = !best_vld_q || (rd_entry.note > best_q.note);
      PRIO_LOW:  take = !best_vld_q || (rd_entry.note < best_q.note);
      default:   take = 1'b1;
    endcase
    take = take && (32'(cnt_q) < 32'(count));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      ev_vel_q   <= '0;
      best_q     <= '0;
      best_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      on_q       <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      trig_q     <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_in) begin
            ev_on_q   <= note_on_in && (velocity_in != '0);
            ev_note_q <= note_num_in;
            ev_vel_q  <= velocity_in;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            state_q   <= StSearch;
          end
        end
        StSearch: begin
          if (cnt_q == ScanLast) begin
            cnt_q   <= '0;
            state_q <= StUpdate;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StUpdate: begin
          best_vld_q <= 1'b0;
          state_q    <= StSelect;
        end
        StSelect: begin
          if (cnt_q == ScanEnd) begin
            if (count == '0) begin
              on_q  <= 1'b0;
              vel_q <= '0;
            end else begin
              on_q   <= 1'b1;
              note_q <= best_q.note;
              vel_q  <= best_q.vel;
              trig_q <= !on_q || (best_q.note != note_q);
            end
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            if (take) begin
              best_q     <= rd_entry;
              best_vld_q <= 1'b1;
            end
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready        = ready_q;
  assign note_on_out  = on_q;
  assign note_num_out = note_q;
  assign velocity_out = vel_q;
  assign trig_out     = trig_q;
  assign count_out    = count;

endmodule
